// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, decode,
// execute, memory and writeback, with a memory-wait watchdog, an
// illegal-instruction trap and a retired-instruction counter.
module multicycle_core_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic [5:0]       dec_type,
  input  logic             is_load,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted
);

  typedef enum logic [2:0] {
    BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT
  } state_t;

  // Watchdog must be able to hold the value TIMEOUT itself.
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd;
  logic            is_u, is_i, is_r, is_s, is_b, is_j;
  logic            wd_active, ready_cur, expire;

  assign {is_u, is_i, is_r, is_s, is_b, is_j} = dec_type;

  // Watchdog only watches the two states that wait on a memory handshake.
  assign wd_active = (state == FETCH) || (state == MEM);
  assign ready_cur = (state == FETCH) ? imem_ready : dmem_ready;
  assign expire    = (TIMEOUT != 0) && wd_active && !ready_cur &&
                     (wd == WD_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Wait counter: restarts whenever the current wait state is left or ready arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     wd <= '0;
    else if (wd_active && !ready_cur && !expire) wd <= wd + 1'b1;
    else                                         wd <= '0;
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              instret <= '0;
    else if (state == WB) instret <= instret + CNT_W'(1);
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    halted    = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        // ready is checked first so a same-cycle arrival beats expiry
        if (imem_ready) begin
          imem_req  = 1'b1;
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end else if (expire) begin
          bus_err   = 1'b1;
          state_nxt = HALT;
        end else begin
          imem_req  = 1'b1;
        end
      end
      DECODE: state_nxt = (dec_type == 6'd0) ? TRAP : EXEC;
      EXEC:   state_nxt = (is_load || is_s) ? MEM : WB;
      MEM: begin
        if (dmem_ready) begin
          dmem_req  = 1'b1;
          dmem_we   = is_s;
          state_nxt = WB;
        end else if (expire) begin
          bus_err   = 1'b1;
          state_nxt = HALT;
        end else begin
          dmem_req  = 1'b1;
          dmem_we   = is_s;
        end
      end
      WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        rf_we  = is_r | is_i | is_u | is_j;
        if (is_jal)                pc_sel = 2'b01;
        else if (is_jalr)          pc_sel = 2'b10;
        else if (is_b && br_taken) pc_sel = 2'b01;
        if (is_load)               wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        state_nxt = FETCH;
      end
      TRAP: begin
        illegal   = 1'b1;
        pc_we     = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = BOOT;
    endcase
    // Strobes are held quiet for the whole time reset is applied.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
      rf_we    = 1'b0;
      wb_sel   = 2'b00;
      retire   = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Directed bench for multicycle_core_ctrl (TIMEOUT = 16, CNT_W = 4).
module tb_multicycle_core_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req, imem_ready, ir_we;
  logic [5:0] dec_type;
  logic       is_load, is_jal, is_jalr, br_taken;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       pc_we, rf_we, retire, illegal, bus_err, halted;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] instret;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_ret = 4'd0;

  localparam logic [5:0] T_U = 6'b100000, T_I = 6'b010000, T_R = 6'b001000,
                         T_S = 6'b000100, T_B = 6'b000010, T_J = 6'b000001;

  multicycle_core_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
    .ir_we(ir_we), .dec_type(dec_type), .is_load(is_load), .is_jal(is_jal),
    .is_jalr(is_jalr), .br_taken(br_taken), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ready(dmem_ready), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire),
    .instret(instret), .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction from FETCH through WB; ends at the WB sample point.
  task automatic instr(input string tag, input logic [5:0] dt, input logic ld,
                       input logic jl, input logic jr, input logic bt,
                       input int fw, input int dw, input logic exp_rf,
                       input logic [1:0] exp_pc, input logic [1:0] exp_wb);
    for (int i = 0; i <= fw; i++) begin
      @(negedge clk);
      imem_ready = (i == fw);
      #1;
      chk({tag, "_imem_req"}, imem_req, 1);
      chk({tag, "_ir_we"}, ir_we, (i == fw));
      chk({tag, "_fetch_bus_err"}, bus_err, 0);
    end
    @(negedge clk);
    imem_ready = 1'b0;
    dec_type = dt; is_load = ld; is_jal = jl; is_jalr = jr; br_taken = bt;
    #1;
    chk({tag, "_dec_pc_we"}, pc_we, 0);
    chk({tag, "_dec_imem_req"}, imem_req, 0);
    @(negedge clk); #1;
    chk({tag, "_exec_dmem_req"}, dmem_req, 0);
    chk({tag, "_exec_pc_we"}, pc_we, 0);
    if (ld || dt[2]) begin
      for (int i = 0; i <= dw; i++) begin
        @(negedge clk);
        dmem_ready = (i == dw);
        #1;
        chk({tag, "_mem_dmem_req"}, dmem_req, 1);
        chk({tag, "_mem_dmem_we"}, dmem_we, dt[2]);
        chk({tag, "_mem_pc_we"}, pc_we, 0);
      end
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk({tag, "_wb_pc_we"}, pc_we, 1);
    chk({tag, "_wb_retire"}, retire, 1);
    chk({tag, "_wb_rf_we"}, rf_we, exp_rf);
    chk({tag, "_wb_pc_sel"}, pc_sel, exp_pc);
    chk({tag, "_wb_wb_sel"}, wb_sel, exp_wb);
    chk({tag, "_wb_dmem_req"}, dmem_req, 0);
    chk({tag, "_instret"}, instret, exp_ret);
    exp_ret = exp_ret + 4'd1;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; dec_type = 6'd0;
    is_load = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; br_taken = 1'b0;
    @(negedge clk); #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_imem_req", imem_req, 0);
    chk("boot_pc_we", pc_we, 0);

    instr("add",    T_R, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00);
    instr("lw",     T_I, 1, 0, 0, 0, 1, 3, 1, 2'b00, 2'b01);
    instr("sw",     T_S, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    instr("beq_t",  T_B, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00);
    instr("beq_n",  T_B, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    instr("jalr",   T_I, 0, 0, 1, 0, 0, 0, 1, 2'b10, 2'b10);
    instr("jal",    T_J, 0, 1, 0, 0, 0, 0, 1, 2'b01, 2'b10);
    instr("lui",    T_U, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00);

    // illegal instruction
    @(negedge clk); imem_ready = 1'b1; #1;
    chk("trap_ir_we", ir_we, 1);
    @(negedge clk);
    imem_ready = 1'b0; dec_type = 6'd0; is_load = 1'b0; is_jal = 1'b0;
    is_jalr = 1'b0; br_taken = 1'b0;
    #1;
    chk("trap_dec_illegal", illegal, 0);
    @(negedge clk); #1;
    chk("trap_illegal", illegal, 1);
    chk("trap_pc_we", pc_we, 1);
    chk("trap_pc_sel", pc_sel, 2'b00);
    chk("trap_rf_we", rf_we, 0);
    chk("trap_retire", retire, 0);
    @(negedge clk); #1;
    chk("trap_after_illegal", illegal, 0);
    chk("trap_after_imem_req", imem_req, 1);
    chk("trap_instret", instret, exp_ret);

    // eight more retires take the 4-bit counter to 16 -> wraps to 0
    for (int k = 0; k < 8; k++)
      instr("add_wrap", T_R, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00);

    // fetch watchdog expiry
    @(negedge clk); imem_ready = 1'b0; #1;
    chk("wrap_instret", instret, 4'd0);
    chk("wd_imem_req_1", imem_req, 1);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk); #1;
      chk("wd_wait_bus_err", bus_err, 0);
      chk("wd_wait_imem_req", imem_req, 1);
    end
    @(negedge clk); #1;
    chk("wd_bus_err", bus_err, 1);
    chk("wd_req_drop", imem_req, 0);
    chk("wd_not_halted_yet", halted, 0);
    @(negedge clk); #1;
    chk("halt_halted", halted, 1);
    chk("halt_bus_err_pulse", bus_err, 0);
    chk("halt_imem_req", imem_req, 0);
    @(negedge clk); imem_ready = 1'b1; #1;
    chk("halt_stays", halted, 1);
    chk("halt_ir_we", ir_we, 0);
    imem_ready = 1'b0;

    // reset leaves HALT
    @(negedge clk); rst = 1'b1; #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_instret", instret, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("boot2_imem_req", imem_req, 0);
    exp_ret = 4'd0;

    // ready arriving on the expiry cycle wins
    instr("add_wdrdy", T_R, 0, 0, 0, 0, 16, 0, 1, 2'b00, 2'b00);

    // reset in the middle of a load's MEM wait
    @(negedge clk); imem_ready = 1'b1; #1;
    @(negedge clk);
    imem_ready = 1'b0; dec_type = T_I; is_load = 1'b1; is_jal = 1'b0;
    is_jalr = 1'b0; br_taken = 1'b0;
    #1;
    @(negedge clk); #1;
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk("mrst_dmem_req_before", dmem_req, 1);
    chk("mrst_instret_before", instret, 4'd1);
    rst = 1'b1;
    #1;
    chk("mrst_dmem_req", dmem_req, 0);
    chk("mrst_instret", instret, 0);
    chk("mrst_pc_we", pc_we, 0);
    chk("mrst_rf_we", rf_we, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("boot3_imem_req", imem_req, 0);
    @(negedge clk); #1;
    chk("fetch3_imem_req", imem_req, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
